pwm_generator_mc: RTL and testbench
===================================

Name: pwm_generator_mc

Overview:
Multi-channel successor to the single-channel PWM generator. It is an AXI4-Lite slave holding a shared period register and per-channel duty/config registers, and it drives N_CH PWM outputs from one free-running counter. Duty and period writes are double-buffered and take effect only at the period boundary, so there are no glitches. It also emits a period tick for interrupt or DMA use. It sits in the PL behind the PS AXI interconnect and drives motor/servo pins.

Parameters:
N_CH, 4, number of PWM channels (1..16)
CNT_W, 16, counter/period/duty width (8..32)
C_S_AXI_DATA_WIDTH, 32, AXI data width (fixed 32)
C_S_AXI_ADDR_WIDTH, 8, AXI byte-address width (must cover 0x10 + 8*N_CH)

Ports:
ACLK  in  1  clock
ARESET  in  1  synchronous active-high reset
s_axi_awaddr/awvalid/awready  in/in/out  ADDR_W/1/1  write address channel
s_axi_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  write data channel
s_axi_bresp/bvalid/bready  out/out/in  2/1/1  write response
s_axi_araddr/arvalid/arready  in/in/out  ADDR_W/1/1  read address
s_axi_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  read data
pwm_out  out  N_CH  PWM outputs
period_tick  out  1  one-cycle pulse when the counter wraps

Behaviour:
- Register map (byte offsets):
  - 0x00 CTRL: bit0 EN (global enable), bit1 FORCE_LOAD (self-clearing, reads 0).
  - 0x04 PERIOD: shadow period, bits [CNT_W-1:0].
  - 0x08 STATUS (RO): bits [CNT_W-1:0] = current counter.
  - 0x10+8n DUTY_n: shadow duty for channel n.
  - 0x14+8n CFG_n: bit0 CH_EN, bit1 POL (1 = inverted).
  - Bits above the field width read 0. Unmapped offsets read 0, writes to them are ignored, and resp is always OKAY (2'b00).
- AXI write:
  - Accept only when awvalid && wvalid are both high and no bvalid is pending.
  - awready and wready pulse high together for 1 cycle.
  - bvalid is asserted on the next cycle and held until bready.
  - wstrb applies per byte.
- AXI read:
  - arready pulses 1 cycle when arvalid is high and rvalid is low.
  - rdata/rvalid are valid the next cycle and held until rready.
  - One outstanding transaction per direction.
- Simultaneous read and write are both serviced independently. A read of a register written in the same cycle returns the old value.
- Counter:
  - EN=0: cnt held at 0.
  - EN=1: cnt increments each cycle. When cnt == act_period it wraps to 0 and period_tick=1 for that cycle.
  - act_period = 0: cnt stays 0 and period_tick is asserted every cycle.
- Shadow load: act_period and all act_duty_n are loaded from the shadows
  - on the wrap cycle, or
  - on any cycle while EN=0, or
  - on the cycle after a FORCE_LOAD write.
  - The new values govern the next counter cycle.
- Compare: raw_n = (cnt < act_duty_n).
  - duty 0 gives constant low.
  - duty > act_period gives constant high (100%).
- Output: pwm_out[n] is registered, 1-cycle latency from cnt. pwm_out[n] = CH_EN_n ? (raw_n ^ POL_n) : POL_n.
  - A disabled channel therefore sits at its idle level.
  - CFG changes take effect immediately; they are not shadowed.
- Reset:
  - All registers, shadows, actives and cnt go to 0.
  - pwm_out = 0, period_tick = 0.
  - All ready/valid outputs = 0, rdata = 0.
  - Reset mid-transaction aborts it; the master must retry.
- Width rule: all comparisons are unsigned on CNT_W bits; upper wdata bits are truncated.

Decomposition:
- pwm_generator_pkg holds:
  - register offset localparams (CTRL, PERIOD, STATUS, CH_BASE=0x10, CH_STRIDE=8);
  - CTRL/CFG bit indices;
  - a typedef struct for channel config {en, pol}.
- Sub-module pwm_channel: holds shadow/active duty, compare, polarity and output register. It is instantiated N_CH times via generate.

Test Plan:
- Reset then read all registers -> all read 0x00000000; pwm_out=0; bresp/rresp OKAY.
- Write PERIOD=9, DUTY_0=3, CFG_0=1, CTRL=1 -> pwm_out[0] high for 3 of every 10 cycles; period_tick every 10 cycles.
- While running, write DUTY_0=7 mid-period -> current period keeps 3 high cycles; from the next wrap, 7 high cycles; no glitch.
- Set CFG_1=3 (enabled, inverted), DUTY_1=0 -> pwm_out[1] constant 1. Then DUTY_1=20 (> period) with CFG_1=1 -> constant 1. Then CFG_1=2 (disabled, POL=1) -> constant 1.
- Write PERIOD=4 followed by CTRL=3 (FORCE_LOAD) -> new period takes effect within 2 cycles; CTRL reads back 0x1.
- Assert ARESET during an active write (awvalid and wvalid held) -> bvalid stays 0, all registers return to 0, pwm_out=0 on the next edge.

Source files
------------

// File: rtl/pwm_generator_pkg.sv
// Shared definitions for the multi-channel PWM generator: register offsets, bit indices, channel config type.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package pwm_generator_pkg;

    // Byte offsets of the AXI4-Lite register map
    localparam int OFF_CTRL    = 'h00;
    localparam int OFF_PERIOD  = 'h04;
    localparam int OFF_STATUS  = 'h08;
    localparam int CH_BASE     = 'h10;
    localparam int CH_STRIDE   = 8;
    localparam int CH_CFG_OFS  = 4;

    // CTRL bits
    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_FORCE_BIT = 1;

    // CFG_n bits
    localparam int CFG_EN_BIT  = 0;
    localparam int CFG_POL_BIT = 1;

    typedef struct packed {
        logic pol;   // 1 = inverted output, also the idle level
        logic en;    // channel enable
    } ch_cfg_t;

    // Byte-lane merge of a write into a 32-bit register image
    function automatic logic [31:0] wstrb_merge(input logic [31:0] old_dat,
                                                input logic [31:0] wr_dat,
                                                input logic [3:0]  strb);
        logic [31:0] m;
        m = old_dat;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) m[8*b +: 8] = wr_dat[8*b +: 8];
        end
        return m;
    endfunction

endpackage

// File: rtl/pwm_generator_mc_channel.sv
// One PWM channel: shadow/active duty, compare against the shared counter, polarity and output flop.
// Latency: pwm_out follows cnt by one cycle; cfg changes show on pwm_out one cycle later.
// Backpressure: none; duty writes are accepted in the cycle duty_wr_vld is high.
// Ports: ACLK/ARESET clock and sync reset; cnt/load from the shared counter; duty_wr_vld/wr_dat/wr_strb
//        shadow-duty write; cfg live channel config; duty_shadow readback; pwm_out registered output.
module pwm_channel
    import pwm_generator_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             ACLK,
    input  logic             ARESET,
    input  logic [CNT_W-1:0] cnt,
    input  logic             load,
    input  logic             duty_wr_vld,
    input  logic [31:0]      wr_dat,
    input  logic [3:0]       wr_strb,
    input  ch_cfg_t          cfg,
    output logic [CNT_W-1:0] duty_shadow,
    output logic             pwm_out
);

    logic [CNT_W-1:0] duty_sh_q, duty_sh_d;
    logic [CNT_W-1:0] act_duty_q, act_duty_d;
    logic             pwm_q, pwm_d;
    logic             raw;

    always_comb begin
        duty_sh_d  = duty_wr_vld ? CNT_W'(wstrb_merge(32'(duty_sh_q), wr_dat, wr_strb)) : duty_sh_q;
        // The active duty only moves at a load point so a period never sees a mid-period change.
        act_duty_d = load ? duty_sh_q : act_duty_q;
        // duty above the period never goes false -> 100%; duty 0 never goes true -> 0%.
        raw        = (cnt < act_duty_q);
        pwm_d      = cfg.en ? (raw ^ cfg.pol) : cfg.pol;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            duty_sh_q  <= '0;
            act_duty_q <= '0;
            pwm_q      <= 1'b0;
        end else begin
            duty_sh_q  <= duty_sh_d;
            act_duty_q <= act_duty_d;
            pwm_q      <= pwm_d;
        end
    end

    assign duty_shadow = duty_sh_q;
    assign pwm_out     = pwm_q;

endmodule

// File: rtl/pwm_generator_mc.sv
// AXI4-Lite multi-channel PWM generator with shared period counter and glitch-free double-buffered updates.
// Latency: write response 1 cycle after the aw/w handshake, read data 1 cycle after ar handshake; pwm 1 cycle after cnt.
// Backpressure: one outstanding transaction per direction; bvalid/rvalid hold until bready/rready.
// Ports: ACLK/ARESET clock and sync active-high reset; s_axi_* AXI4-Lite slave; pwm_out[N_CH] outputs;
//        period_tick one-cycle pulse on counter wrap.
module pwm_generator_mc
    import pwm_generator_pkg::*;
#(
    parameter int N_CH               = 4,
    parameter int CNT_W              = 16,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 8
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic [N_CH-1:0]                 pwm_out,
    output logic                            period_tick
);

    // AXI handshake state
    logic        awready_q, awready_d;
    logic        bvalid_q,  bvalid_d;
    logic        arready_q, arready_d;
    logic        rvalid_q,  rvalid_d;
    logic [31:0] rdata_q,   rdata_d;

    // Register and counter state
    logic                  en_q, en_d;
    logic                  force_q, force_d;
    logic [CNT_W-1:0]      period_sh_q, period_sh_d;
    logic [CNT_W-1:0]      act_period_q, act_period_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    ch_cfg_t [N_CH-1:0]    cfg_q, cfg_d;

    logic                  wr_fire, rd_fire;
    logic                  wrap, load;
    logic [N_CH-1:0]       duty_wr;
    logic [CNT_W-1:0]      duty_sh [N_CH];
    logic [31:0]           rd_mux;
    int                    wr_off, rd_off;

    assign wr_off = int'(s_axi_awaddr);
    assign rd_off = int'(s_axi_araddr);

    // Write channel, register updates and counter
    always_comb begin
        // awready is held off for the cycle it is high, giving a single-cycle pulse per transaction.
        awready_d   = s_axi_awvalid && s_axi_wvalid && !bvalid_q && !awready_q;
        wr_fire     = awready_q && s_axi_awvalid && s_axi_wvalid;
        bvalid_d    = bvalid_q ? !s_axi_bready : wr_fire;

        en_d        = en_q;
        force_d     = 1'b0;
        period_sh_d = period_sh_q;
        cfg_d       = cfg_q;
        duty_wr     = '0;

        if (wr_fire) begin
            if (wr_off == OFF_CTRL && s_axi_wstrb[0]) begin
                en_d    = s_axi_wdata[CTRL_EN_BIT];
                force_d = s_axi_wdata[CTRL_FORCE_BIT];
            end
            if (wr_off == OFF_PERIOD) begin
                period_sh_d = CNT_W'(wstrb_merge(32'(period_sh_q), s_axi_wdata, s_axi_wstrb));
            end
            for (int n = 0; n < N_CH; n++) begin
                if (wr_off == CH_BASE + CH_STRIDE*n) begin
                    duty_wr[n] = 1'b1;
                end
                if (wr_off == CH_BASE + CH_STRIDE*n + CH_CFG_OFS && s_axi_wstrb[0]) begin
                    cfg_d[n].en  = s_axi_wdata[CFG_EN_BIT];
                    cfg_d[n].pol = s_axi_wdata[CFG_POL_BIT];
                end
            end
        end

        // >= rather than == so a forced load of a shorter period with the counter
        // already beyond it wraps at once instead of running to counter overflow.
        wrap         = en_q && (cnt_q >= act_period_q);
        load         = wrap || !en_q || force_q;
        cnt_d        = (!en_q || wrap) ? '0 : cnt_q + CNT_W'(1);
        act_period_d = load ? period_sh_q : act_period_q;
    end

    // Read mux samples current state, so a same-cycle write is not yet visible
    always_comb begin
        rd_mux = '0;
        if (rd_off == OFF_CTRL) begin
            rd_mux[CTRL_EN_BIT] = en_q;
        end else if (rd_off == OFF_PERIOD) begin
            rd_mux = 32'(period_sh_q);
        end else if (rd_off == OFF_STATUS) begin
            rd_mux = 32'(cnt_q);
        end
        for (int n = 0; n < N_CH; n++) begin
            if (rd_off == CH_BASE + CH_STRIDE*n) begin
                rd_mux = 32'(duty_sh[n]);
            end
            if (rd_off == CH_BASE + CH_STRIDE*n + CH_CFG_OFS) begin
                rd_mux[CFG_EN_BIT]  = cfg_q[n].en;
                rd_mux[CFG_POL_BIT] = cfg_q[n].pol;
            end
        end
    end

    always_comb begin
        arready_d = s_axi_arvalid && !rvalid_q && !arready_q;
        rd_fire   = arready_q && s_axi_arvalid;
        rvalid_d  = rvalid_q ? !s_axi_rready : rd_fire;
        rdata_d   = rd_fire ? rd_mux : rdata_q;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            awready_q    <= 1'b0;
            bvalid_q     <= 1'b0;
            arready_q    <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            en_q         <= 1'b0;
            force_q      <= 1'b0;
            period_sh_q  <= '0;
            act_period_q <= '0;
            cnt_q        <= '0;
            cfg_q        <= '0;
        end else begin
            awready_q    <= awready_d;
            bvalid_q     <= bvalid_d;
            arready_q    <= arready_d;
            rvalid_q     <= rvalid_d;
            rdata_q      <= rdata_d;
            en_q         <= en_d;
            force_q      <= force_d;
            period_sh_q  <= period_sh_d;
            act_period_q <= act_period_d;
            cnt_q        <= cnt_d;
            cfg_q        <= cfg_d;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        pwm_channel #(.CNT_W(CNT_W)) u_ch (
            .ACLK        (ACLK),
            .ARESET      (ARESET),
            .cnt         (cnt_q),
            .load        (load),
            .duty_wr_vld (duty_wr[g]),
            .wr_dat      (s_axi_wdata),
            .wr_strb     (s_axi_wstrb),
            .cfg         (cfg_q[g]),
            .duty_shadow (duty_sh[g]),
            .pwm_out     (pwm_out[g])
        );
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = awready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = 2'b00;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = 2'b00;
    assign period_tick   = wrap;

endmodule

// File: tb/tb_pwm_generator_mc.sv
// Directed bench for pwm_generator_mc: register access, PWM patterns, shadow timing, force load, reset.
// Latency: n/a.
// Backpressure: master drives one transaction at a time and waits for each response.
module tb_pwm_generator_mc;

    localparam int N_CH  = 4;
    localparam int CNT_W = 16;

    logic            ACLK = 1'b0;
    logic            ARESET;
    logic [7:0]      s_axi_awaddr;
    logic            s_axi_awvalid;
    logic            s_axi_awready;
    logic [31:0]     s_axi_wdata;
    logic [3:0]      s_axi_wstrb;
    logic            s_axi_wvalid;
    logic            s_axi_wready;
    logic [1:0]      s_axi_bresp;
    logic            s_axi_bvalid;
    logic            s_axi_bready;
    logic [7:0]      s_axi_araddr;
    logic            s_axi_arvalid;
    logic            s_axi_arready;
    logic [31:0]     s_axi_rdata;
    logic [1:0]      s_axi_rresp;
    logic            s_axi_rvalid;
    logic            s_axi_rready;
    logic [N_CH-1:0] pwm_out;
    logic            period_tick;

    int checks   = 0;
    int failures = 0;

    logic [N_CH-1:0] pwm_s  [0:31];
    logic            tick_s [0:31];

    pwm_generator_mc #(.N_CH(N_CH), .CNT_W(CNT_W), .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(8)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .pwm_out(pwm_out), .period_tick(period_tick)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    // All stimulus tasks start and end on a falling edge.
    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int n;
        s_axi_awaddr = addr; s_axi_wdata = data; s_axi_wstrb = strb;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        n = 0;
        @(negedge ACLK);
        while (!s_axi_awready && n < 20) begin @(negedge ACLK); n++; end
        if (!s_axi_awready) begin
            checks++; failures++;
            $display("FAIL wr_awready addr=%h: awready=%b required 1 within 20 cycles", addr, s_axi_awready);
            s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
            return;
        end
        @(negedge ACLK);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        n = 0;
        while (!s_axi_bvalid && n < 20) begin @(negedge ACLK); n++; end
        checks++;
        if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== 2'b00) begin
            failures++;
            $display("FAIL wr_bresp addr=%h: bvalid=%b bresp=%b required 1/00", addr, s_axi_bvalid, s_axi_bresp);
        end
        s_axi_bready = 1'b1;
        @(negedge ACLK);
        s_axi_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [7:0] addr, output logic [31:0] data);
        int n;
        s_axi_araddr = addr; s_axi_arvalid = 1'b1;
        n = 0;
        data = 32'hDEAD_BEEF;
        @(negedge ACLK);
        while (!s_axi_arready && n < 20) begin @(negedge ACLK); n++; end
        if (!s_axi_arready) begin
            checks++; failures++;
            $display("FAIL rd_arready addr=%h: arready=%b required 1 within 20 cycles", addr, s_axi_arready);
            s_axi_arvalid = 1'b0;
            return;
        end
        @(negedge ACLK);
        s_axi_arvalid = 1'b0;
        n = 0;
        while (!s_axi_rvalid && n < 20) begin @(negedge ACLK); n++; end
        checks++;
        if (s_axi_rvalid !== 1'b1 || s_axi_rresp !== 2'b00) begin
            failures++;
            $display("FAIL rd_rresp addr=%h: rvalid=%b rresp=%b required 1/00", addr, s_axi_rvalid, s_axi_rresp);
        end
        data = s_axi_rdata;
        s_axi_rready = 1'b1;
        @(negedge ACLK);
        s_axi_rready = 1'b0;
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        while (period_tick !== 1'b1 && n < 100) begin @(negedge ACLK); n++; end
        if (period_tick !== 1'b1) begin
            checks++; failures++;
            $display("FAIL wait_tick: period_tick=%b required 1 within 100 cycles", period_tick);
        end
    endtask

    task automatic sample_window(input int n);
        for (int i = 1; i <= n; i++) begin
            @(negedge ACLK);
            pwm_s[i]  = pwm_out;
            tick_s[i] = period_tick;
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic [7:0]  addrs [15];
        addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C,
                  8'h20, 8'h24, 8'h28, 8'h2C, 8'h30, 8'h34, 8'h40};
        ARESET = 1'b1;
        s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
        s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = '0; s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b0;
        repeat (3) @(negedge ACLK);
        ARESET = 1'b0;
        @(negedge ACLK);
        checks++;
        if ({pwm_out, period_tick} !== 5'b0) begin
            failures++;
            $display("FAIL reset_outputs: pwm_out=%b tick=%b required 0000/0", pwm_out, period_tick);
        end
        checks++;
        if ({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid} !== 5'b0 ||
            s_axi_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_axi: aw/w/b/ar/r=%b%b%b%b%b rdata=%h required 00000/0",
                     s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid, s_axi_rdata);
        end
        foreach (addrs[k]) begin
            axi_read(addrs[k], rd);
            checks++;
            if (rd !== 32'h0) begin
                failures++;
                $display("FAIL reset_read addr=%h: got %h required 00000000", addrs[k], rd);
            end
        end
        axi_write(8'h0C, 32'hFFFF_FFFF, 4'hF);
        axi_read(8'h0C, rd);
        checks++;
        if (rd !== 32'h0) begin
            failures++;
            $display("FAIL unmapped_write: got %h required 00000000", rd);
        end
    endtask

    task automatic test_basic();
        logic [31:0] rd;
        int bad;
        axi_write(8'h04, 32'd9, 4'hF);
        axi_write(8'h10, 32'd3, 4'hF);
        axi_write(8'h14, 32'd1, 4'hF);
        axi_write(8'h00, 32'd1, 4'hF);
        wait_tick();
        sample_window(25);
        bad = 0;
        // sample i sees pwm of counter value (i+8)%10 (counter is 9 at the sync tick, pwm lags one cycle)
        for (int i = 2; i <= 25; i++) if (pwm_s[i][0] !== (((i + 8) % 10) < 3)) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL basic_pwm0: %0d samples differ from 3-of-10 high, required 0", bad);
        end
        bad = 0;
        for (int i = 1; i <= 25; i++) if (tick_s[i] !== (i % 10 == 0)) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL basic_tick: %0d samples differ from tick every 10 cycles, required 0", bad);
        end
        axi_read(8'h04, rd);
        checks++;
        if (rd !== 32'd9) begin failures++; $display("FAIL basic_period_rd: got %h required 00000009", rd); end
        axi_read(8'h00, rd);
        checks++;
        if (rd !== 32'd1) begin failures++; $display("FAIL basic_ctrl_rd: got %h required 00000001", rd); end
    endtask

    task automatic test_duty_update();
        int bad;
        wait_tick();
        fork
            axi_write(8'h10, 32'd7, 4'hF);
            sample_window(25);
        join
        bad = 0;
        // counter samples 1..10 belong to the period already running (duty 3), 11.. to the next (duty 7)
        for (int i = 2; i <= 25; i++)
            if (pwm_s[i][0] !== (((i + 8) % 10) < ((i - 1 <= 10) ? 3 : 7))) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL duty_update: %0d samples differ from 3-high then 7-high, required 0", bad);
        end
    endtask

    task automatic test_channels();
        int bad1, bad2;
        logic [31:0] cfgs  [4];
        logic [31:0] dutys [4];
        logic        want  [4];
        cfgs  = '{32'd3, 32'd1, 32'd0, 32'd2};
        dutys = '{32'd0, 32'd20, 32'd20, 32'd0};
        want  = '{1'b1, 1'b1, 1'b0, 1'b1};
        for (int s = 0; s < 4; s++) begin
            axi_write(8'h1C, cfgs[s], 4'hF);
            axi_write(8'h18, dutys[s], 4'hF);
            wait_tick();
            repeat (2) @(negedge ACLK);
            sample_window(20);
            bad1 = 0; bad2 = 0;
            for (int i = 1; i <= 20; i++) begin
                if (pwm_s[i][1] !== want[s]) bad1++;
                if (pwm_s[i][2] !== 1'b0) bad2++;
            end
            checks++;
            if (bad1 != 0) begin
                failures++;
                $display("FAIL ch1_step%0d: %0d samples of pwm_out[1] differ from constant %b", s, bad1, want[s]);
            end
            checks++;
            if (bad2 != 0) begin
                failures++;
                $display("FAIL ch2_idle_step%0d: %0d samples of pwm_out[2] differ from constant 0", s, bad2);
            end
        end
        axi_write(8'h1C, 32'd1, 4'hF);
        wait_tick();
        repeat (2) @(negedge ACLK);
        sample_window(20);
        bad1 = 0;
        for (int i = 1; i <= 20; i++) if (pwm_s[i][1] !== 1'b0) bad1++;
        checks++;
        if (bad1 != 0) begin
            failures++;
            $display("FAIL ch1_duty0: %0d samples of pwm_out[1] differ from constant 0", bad1);
        end
    endtask

    task automatic test_force_load();
        logic [31:0] rd;
        int first, bad;
        wait_tick();
        fork
            begin
                axi_write(8'h04, 32'd4, 4'hF);
                axi_write(8'h00, 32'd3, 4'hF);
            end
            sample_window(25);
        join
        first = 0;
        for (int i = 1; i <= 25; i++) if (tick_s[i] === 1'b1 && first == 0) first = i;
        checks++;
        if (first == 0 || first >= 10) begin
            failures++;
            $display("FAIL force_early: first tick at sample %0d, required 1..9", first);
        end
        bad = 0;
        if (first != 0)
            for (int i = first; i <= 25; i++) if (tick_s[i] !== ((i - first) % 5 == 0)) bad++;
        checks++;
        if (bad != 0 || first == 0) begin
            failures++;
            $display("FAIL force_period: %0d samples differ from tick every 5 cycles, required 0", bad);
        end
        axi_read(8'h00, rd);
        checks++;
        if (rd !== 32'h1) begin failures++; $display("FAIL force_ctrl_rd: got %h required 00000001", rd); end
        axi_read(8'h08, rd);
        checks++;
        if (rd > 32'd4) begin failures++; $display("FAIL force_status: got %h required <= 00000004", rd); end
    endtask

    task automatic test_period_zero();
        logic [31:0] rd;
        int bad;
        axi_write(8'h04, 32'd0, 4'hF);
        axi_write(8'h00, 32'd3, 4'hF);
        repeat (3) @(negedge ACLK);
        sample_window(10);
        bad = 0;
        for (int i = 1; i <= 10; i++) if (tick_s[i] !== 1'b1 || pwm_s[i][0] !== 1'b1) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL period_zero: %0d samples without tick=1/pwm0=1, required 0", bad);
        end
        axi_read(8'h08, rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL period_zero_status: got %h required 00000000", rd); end
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] rd;
        logic [7:0]  addrs [5];
        addrs = '{8'h00, 8'h04, 8'h10, 8'h14, 8'h1C};
        s_axi_awaddr = 8'h04; s_axi_wdata = 32'h55; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1;
        ARESET = 1'b1;
        @(negedge ACLK);
        checks++;
        if ({s_axi_bvalid, s_axi_awready, pwm_out, period_tick} !== 7'b0) begin
            failures++;
            $display("FAIL rst_mid_edge1: bvalid=%b awready=%b pwm=%b tick=%b required 0/0/0000/0",
                     s_axi_bvalid, s_axi_awready, pwm_out, period_tick);
        end
        @(negedge ACLK);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        ARESET = 1'b0;
        @(negedge ACLK);
        checks++;
        if (s_axi_bvalid !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_bvalid: bvalid=%b required 0", s_axi_bvalid);
        end
        foreach (addrs[k]) begin
            axi_read(addrs[k], rd);
            checks++;
            if (rd !== 32'h0) begin
                failures++;
                $display("FAIL rst_mid_read addr=%h: got %h required 00000000", addrs[k], rd);
            end
        end
    endtask

    task automatic test_wstrb();
        logic [31:0] rd;
        axi_write(8'h04, 32'hAABB_CCDD, 4'b0011);
        axi_read(8'h04, rd);
        checks++;
        if (rd !== 32'h0000_CCDD) begin failures++; $display("FAIL wstrb_low: got %h required 0000ccdd", rd); end
        axi_write(8'h04, 32'h0000_11EE, 4'b0010);
        axi_read(8'h04, rd);
        checks++;
        if (rd !== 32'h0000_11DD) begin failures++; $display("FAIL wstrb_byte1: got %h required 000011dd", rd); end
        axi_write(8'h20, 32'hFFFF_1234, 4'hF);
        axi_read(8'h20, rd);
        checks++;
        if (rd !== 32'h0000_1234) begin failures++; $display("FAIL duty_trunc: got %h required 00001234", rd); end
        axi_write(8'h2C, 32'hFFFF_FFFF, 4'hF);
        axi_read(8'h2C, rd);
        checks++;
        if (rd !== 32'h0000_0003) begin failures++; $display("FAIL cfg_mask: got %h required 00000003", rd); end
    endtask

    initial begin
        ARESET = 1'b1;
        test_reset();
        test_basic();
        test_duty_update();
        test_channels();
        test_force_load();
        test_period_zero();
        test_reset_mid_write();
        test_wstrb();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
